cabac_pu_debinari_mv: RTL

Decoder-side counterpart of the PU motion-vector binarizer: consumes decoded bins one at a time from the CABAC arithmetic-decoding engine and rebuilds one PU's motion vector difference (mvd_x, mvd_y) and MVP index. It sits between the bin decoder and the inter-CU parameter store in the loop-back/verification decode path. It drives the bin-request handshake, selecting the context index or bypass mode for every bin. It parses the HEVC syntax order: greater0 flags, greater1 flags, EG1 remainders with signs, then the mvp flag.

---
 rtl/cabac_pu_debinari_mv_if.sv | 27 ++
 rtl/cabac_pu_debinari_mv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_pu_debinari_mv_if.sv
// Bin-request channel between the PU mvd debinarizer and the CABAC bin decoder.
// Handshake: the debinarizer raises bin_req_o with bin_byp_o/bin_ctx_o and holds all three
// stable until a cycle where bin_req_o & bin_vld_i, which is the single transfer of bin_i;
// bin_vld_i while bin_req_o is low carries no meaning.
interface cabac_pu_debinari_mv_if;
  logic       bin_req_o;
  logic       bin_byp_o;
  logic [7:0] bin_ctx_o;
  logic       bin_vld_i;
  logic       bin_i;

  modport master (
    output bin_req_o,
    output bin_byp_o,
    output bin_ctx_o,
    input  bin_vld_i,
    input  bin_i
  );

  modport slave (
    input  bin_req_o,
    input  bin_byp_o,
    input  bin_ctx_o,
    output bin_vld_i,
    output bin_i
  );
endinterface

// File: rtl/cabac_pu_debinari_mv.sv
// Rebuilds one PU's mvd pair and mvp index from decoded bins in HEVC syntax order
// (greater0, greater1, EG1 remainder + sign per component, mvp flag).
module cabac_pu_debinari_mv #(
  parameter int         MVD_WIDTH = 11,
  parameter logic [7:0] CTX_GR0   = 8'd0,
  parameter logic [7:0] CTX_GR1   = 8'd1,
  parameter logic [7:0] CTX_MVP   = 8'd2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  cabac_pu_debinari_mv_if.master      bin_if,
  output logic                        done_o,
  output logic                        err_o,
  output logic [MVD_WIDTH-1:0]        mvd_x_o,
  output logic [MVD_WIDTH-1:0]        mvd_y_o,
  output logic [2:0]                  mvp_idx_o,
  output logic [3:0]                  state_dbg_o
);

  localparam int                  KW    = $clog2(MVD_WIDTH) + 1;
  localparam logic [KW-1:0]       K_MAX = KW'(MVD_WIDTH - 2);
  localparam logic [KW-1:0]       K_ONE = KW'(1);
  localparam logic [MVD_WIDTH-1:0] ONE  = MVD_WIDTH'(1);
  localparam logic [MVD_WIDTH-1:0] TWO  = MVD_WIDTH'(2);

  typedef enum logic [3:0] {
    S_IDLE, S_GR0_X, S_GR0_Y, S_GR1_X, S_GR1_Y,
    S_PFX_X, S_SFX_X, S_SGN_X, S_PFX_Y, S_SFX_Y, S_SGN_Y,
    S_MVP, S_DONE
  } state_t;

  // First state at or after s whose bin is actually present for these flags.
  function automatic state_t skip_from(state_t s, logic g0x, logic g0y, logic g1x, logic g1y);
    state_t r;
    r = s;
    if (r == S_GR1_X && !g0x) r = S_GR1_Y;
    if (r == S_GR1_Y && !g0y) r = S_PFX_X;
    if (r == S_PFX_X && !g1x) r = S_SGN_X;
    if (r == S_SGN_X && !g0x) r = S_PFX_Y;
    if (r == S_PFX_Y && !g1y) r = S_SGN_Y;
    if (r == S_SGN_Y && !g0y) r = S_MVP;
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic                   gr0x_q, gr0x_d, gr0y_q, gr0y_d;
  logic                   gr1x_q, gr1x_d, gr1y_q, gr1y_d;
  logic [KW-1:0]          k_q, k_d;
  logic [MVD_WIDTH-1:0]   val_q, val_d;
  logic [MVD_WIDTH-1:0]   mag_x_q, mag_x_d, mag_y_q, mag_y_d;
  logic                   sign_x_q, sign_x_d, sign_y_q, sign_y_d;
  logic                   req_q, req_d, byp_q, byp_d;
  logic [7:0]             ctx_q, ctx_d;
  logic                   done_q, done_d, err_q, err_d;
  logic [MVD_WIDTH-1:0]   mvd_x_q, mvd_x_d, mvd_y_q, mvd_y_d;
  logic [2:0]             mvp_idx_q, mvp_idx_d;
  logic [MVD_WIDTH-1:0]   sfx_sum;
  logic                   xfer;

  assign xfer = req_q & bin_if.bin_vld_i;

  always_comb begin
    state_d   = state_q;
    gr0x_d    = gr0x_q;
    gr0y_d    = gr0y_q;
    gr1x_d    = gr1x_q;
    gr1y_d    = gr1y_q;
    k_d       = k_q;
    val_d     = val_q;
    mag_x_d   = mag_x_q;
    mag_y_d   = mag_y_q;
    sign_x_d  = sign_x_q;
    sign_y_d  = sign_y_q;
    err_d     = err_q;
    mvd_x_d   = mvd_x_q;
    mvd_y_d   = mvd_y_q;
    mvp_idx_d = mvp_idx_q;
    sfx_sum   = val_q + ({{(MVD_WIDTH-1){1'b0}}, bin_if.bin_i} << (k_q - K_ONE));

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_GR0_X;
          gr0x_d   = 1'b0;
          gr0y_d   = 1'b0;
          gr1x_d   = 1'b0;
          gr1y_d   = 1'b0;
          k_d      = K_ONE;
          val_d    = '0;
          mag_x_d  = '0;
          mag_y_d  = '0;
          sign_x_d = 1'b0;
          sign_y_d = 1'b0;
        end
      end
      S_GR0_X: if (xfer) begin
        gr0x_d  = bin_if.bin_i;
        mag_x_d = bin_if.bin_i ? ONE : '0;
        state_d = S_GR0_Y;
      end
      S_GR0_Y: if (xfer) begin
        gr0y_d  = bin_if.bin_i;
        mag_y_d = bin_if.bin_i ? ONE : '0;
        state_d = skip_from(S_GR1_X, gr0x_q, bin_if.bin_i, 1'b0, 1'b0);
      end
      S_GR1_X: if (xfer) begin
        gr1x_d  = bin_if.bin_i;
        state_d = skip_from(S_GR1_Y, gr0x_q, gr0y_q, bin_if.bin_i, 1'b0);
      end
      S_GR1_Y: if (xfer) begin
        gr1y_d  = bin_if.bin_i;
        state_d = skip_from(S_PFX_X, gr0x_q, gr0y_q, gr1x_q, bin_if.bin_i);
      end
      S_PFX_X, S_PFX_Y: if (xfer) begin
        if (bin_if.bin_i) begin
          // A prefix this long cannot encode a legal magnitude: abandon the PU.
          if (k_q == K_MAX) begin
            err_d     = 1'b1;
            mvd_x_d   = '0;
            mvd_y_d   = '0;
            mvp_idx_d = '0;
            state_d   = S_DONE;
          end else begin
            val_d = val_q + (ONE << k_q);
            k_d   = k_q + K_ONE;
          end
        end else begin
          state_d = (state_q == S_PFX_X) ? S_SFX_X : S_SFX_Y;
        end
      end
      S_SFX_X, S_SFX_Y: if (xfer) begin
        val_d = sfx_sum;
        k_d   = k_q - K_ONE;
        if (k_q == K_ONE) begin
          val_d = '0;
          k_d   = K_ONE;
          if (state_q == S_SFX_X) begin
            mag_x_d = TWO + sfx_sum;
            state_d = S_SGN_X;
          end else begin
            mag_y_d = TWO + sfx_sum;
            state_d = S_SGN_Y;
          end
        end
      end
      S_SGN_X: if (xfer) begin
        sign_x_d = bin_if.bin_i;
        state_d  = skip_from(S_PFX_Y, gr0x_q, gr0y_q, gr1x_q, gr1y_q);
      end
      S_SGN_Y: if (xfer) begin
        sign_y_d = bin_if.bin_i;
        state_d  = S_MVP;
      end
      S_MVP: if (xfer) begin
        err_d     = 1'b0;
        mvd_x_d   = sign_x_q ? (~mag_x_q + ONE) : mag_x_q;
        mvd_y_d   = sign_y_q ? (~mag_y_q + ONE) : mag_y_q;
        mvp_idx_d = {2'b00, bin_if.bin_i};
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Request fields are registered from the next state so they are stable for the whole bin.
    done_d = (state_d == S_DONE);
    req_d  = 1'b0;
    byp_d  = 1'b0;
    ctx_d  = 8'd0;
    case (state_d)
      S_GR0_X, S_GR0_Y: begin req_d = 1'b1; ctx_d = CTX_GR0; end
      S_GR1_X, S_GR1_Y: begin req_d = 1'b1; ctx_d = CTX_GR1; end
      S_PFX_X, S_SFX_X, S_SGN_X,
      S_PFX_Y, S_SFX_Y, S_SGN_Y: begin req_d = 1'b1; byp_d = 1'b1; end
      S_MVP:            begin req_d = 1'b1; ctx_d = CTX_MVP; end
      default:          ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gr0x_q    <= 1'b0;
      gr0y_q    <= 1'b0;
      gr1x_q    <= 1'b0;
      gr1y_q    <= 1'b0;
      k_q       <= K_ONE;
      val_q     <= '0;
      mag_x_q   <= '0;
      mag_y_q   <= '0;
      sign_x_q  <= 1'b0;
      sign_y_q  <= 1'b0;
      req_q     <= 1'b0;
      byp_q     <= 1'b0;
      ctx_q     <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mvd_x_q   <= '0;
      mvd_y_q   <= '0;
      mvp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      gr0x_q    <= gr0x_d;
      gr0y_q    <= gr0y_d;
      gr1x_q    <= gr1x_d;
      gr1y_q    <= gr1y_d;
      k_q       <= k_d;
      val_q     <= val_d;
      mag_x_q   <= mag_x_d;
      mag_y_q   <= mag_y_d;
      sign_x_q  <= sign_x_d;
      sign_y_q  <= sign_y_d;
      req_q     <= req_d;
      byp_q     <= byp_d;
      ctx_q     <= ctx_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mvd_x_q   <= mvd_x_d;
      mvd_y_q   <= mvd_y_d;
      mvp_idx_q <= mvp_idx_d;
    end
  end

  assign bin_if.bin_req_o = req_q;
  assign bin_if.bin_byp_o = byp_q;
  assign bin_if.bin_ctx_o = ctx_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign mvd_x_o          = mvd_x_q;
  assign mvd_y_o          = mvd_y_q;
  assign mvp_idx_o        = mvp_idx_q;
  assign state_dbg_o      = state_q;

endmodule
